exe_wb_stage: RTL and testbench

// - Writeback stage directly downstream of the ALU: captures each registered ALU result (valid pulse + 128b

---
 rtl/exe_wb_stage.sv | 114 +++++++++++
 tb/tb_exe_wb_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_wb_stage.sv
// Writeback stage behind the ALU: buffers registered results in a small FIFO and retires them to
// the register-file write port, splitting wide results into a low write and a high write.
module exe_wb_stage #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned HI_IDX = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     exe_valid,
   input  logic [127:0]             exe_result,
   input  logic [IDX_W-1:0]         exe_dest,
   input  logic                     exe_wr_en,
   input  logic                     exe_wide,
   output logic                     stall_exe,
   output logic                     rf_wr_en,
   output logic [IDX_W-1:0]         rf_wr_idx,
   output logic [63:0]              rf_wr_data,
   input  logic                     rf_grant,
   output logic [15:0]              sb_clr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow_err
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic PhLo = 1'b0;
   localparam logic PhHi = 1'b1;

   logic [127:0]      res_q  [DEPTH];
   logic [IDX_W-1:0]  dest_q [DEPTH];
   logic              wide_q [DEPTH];

   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              phase_q, phase_d;
   logic [15:0]       sb_clr_q, sb_clr_d;
   logic              ovf_q, ovf_d;

   logic              empty, full, req_push, push, pop;

   always_comb begin
      empty      = (count_q == '0);
      full       = (count_q == CntW'(DEPTH));
      rf_wr_en   = !empty;
      rf_wr_idx  = '0;
      rf_wr_data = '0;
      if (!empty) begin
         if (phase_q == PhHi) begin
            rf_wr_idx  = IDX_W'(HI_IDX);
            rf_wr_data = res_q[rd_ptr_q][127:64];
         end else begin
            rf_wr_idx  = dest_q[rd_ptr_q];
            rf_wr_data = res_q[rd_ptr_q][63:0];
         end
      end

      // A wide entry only pops after its high half has been granted.
      pop     = 1'b0;
      phase_d = phase_q;
      if (!empty && rf_grant) begin
         if (phase_q == PhLo && wide_q[rd_ptr_q]) begin
            phase_d = PhHi;
         end else begin
            pop     = 1'b1;
            phase_d = PhLo;
         end
      end

      req_push = exe_valid & exe_wr_en;
      push     = req_push & (!full | pop);
      ovf_d    = ovf_q | (req_push & full & !pop);

      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      count_d  = count_q + CntW'(push) - CntW'(pop);
      sb_clr_d = pop ? (16'(1) << dest_q[rd_ptr_q]) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         phase_q  <= PhLo;
         sb_clr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         phase_q  <= phase_d;
         sb_clr_q <= sb_clr_d;
         ovf_q    <= ovf_d;
      end
   end

   // Payload storage needs no reset; occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (push) begin
         res_q[wr_ptr_q]  <= exe_result;
         dest_q[wr_ptr_q] <= exe_dest;
         wide_q[wr_ptr_q] <= exe_wide;
      end
   end

   assign stall_exe    = (count_q >= CntW'(DEPTH - 1));
   assign sb_clr       = sb_clr_q;
   assign count        = count_q;
   assign overflow_err = ovf_q;

endmodule

// File: tb/tb_exe_wb_stage.sv
// Randomised scoreboard bench for exe_wb_stage: a queue-level reference model predicts every
// register-file write, scoreboard clear, occupancy, stall and overflow flag.
module tb_exe_wb_stage;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned HI_IDX = 2;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     exe_valid;
   logic [127:0]             exe_result;
   logic [IDX_W-1:0]         exe_dest;
   logic                     exe_wr_en;
   logic                     exe_wide;
   logic                     stall_exe;
   logic                     rf_wr_en;
   logic [IDX_W-1:0]         rf_wr_idx;
   logic [63:0]              rf_wr_data;
   logic                     rf_grant;
   logic [15:0]              sb_clr;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow_err;

   exe_wb_stage #(.DEPTH(DEPTH), .IDX_W(IDX_W), .HI_IDX(HI_IDX)) dut (
      .clk          (clk),
      .reset        (reset),
      .exe_valid    (exe_valid),
      .exe_result   (exe_result),
      .exe_dest     (exe_dest),
      .exe_wr_en    (exe_wr_en),
      .exe_wide     (exe_wide),
      .stall_exe    (stall_exe),
      .rf_wr_en     (rf_wr_en),
      .rf_wr_idx    (rf_wr_idx),
      .rf_wr_data   (rf_wr_data),
      .rf_grant     (rf_grant),
      .sb_clr       (sb_clr),
      .count        (count),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0]     res;
      logic [IDX_W-1:0] dest;
      logic             wide;
   } entry_t;

   typedef struct {
      logic [IDX_W-1:0] idx;
      logic [63:0]      data;
   } wr_t;

   entry_t m_q[$];
   wr_t    exp_wr[$];
   bit     m_half;
   bit     m_ovf;
   logic [15:0] m_sb;
   bit     mon_en = 1'b0;
   int     n_cmp = 0;
   int     n_bad = 0;

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endfunction

   // Applies the effect of the posedge that just occurred, using the inputs held across it.
   task automatic model_apply();
      bit     pop;
      entry_t e;
      if (reset) begin
         m_q.delete();
         exp_wr.delete();
         m_half = 0;
         m_ovf  = 0;
         m_sb   = '0;
         return;
      end
      pop  = 0;
      m_sb = '0;
      if (m_q.size() != 0 && rf_grant) begin
         if (m_q[0].wide && !m_half) m_half = 1;
         else pop = 1;
      end
      if (pop) m_sb = 16'(1) << m_q[0].dest;
      if (exe_valid && exe_wr_en) begin
         if (m_q.size() < DEPTH || pop) begin
            e.res  = exe_result;
            e.dest = exe_dest;
            e.wide = exe_wide;
            exp_wr.push_back('{idx: exe_dest, data: exe_result[63:0]});
            if (exe_wide) exp_wr.push_back('{idx: IDX_W'(HI_IDX), data: exe_result[127:64]});
         end else begin
            m_ovf = 1;
         end
      end
      if (pop) begin
         void'(m_q.pop_front());
         m_half = 0;
      end
      if (exe_valid && exe_wr_en && (m_q.size() < DEPTH) && !(m_q.size() == DEPTH - 1 && !pop
          && m_ovf && 0)) begin
      end
      if (exe_valid && exe_wr_en && exp_accept_pending(pop)) m_q.push_back(e);
   endtask

   // Acceptance is decided on pre-pop occupancy; recorded here so push ordering stays after pop.
   bit last_accept;
   function automatic bit exp_accept_pending(bit pop);
      return last_accept;
   endfunction

   task automatic step(input logic rst, input logic v, input logic wr, input logic wide,
                       input logic g, input logic [IDX_W-1:0] d, input logic [127:0] r);
      @(posedge clk);
      last_accept = (m_q.size() < DEPTH) || (m_q.size() != 0 && rf_grant
                    && !(m_q[0].wide && !m_half));
      model_apply();
      #1;
      reset      = rst;
      exe_valid  = v;
      exe_wr_en  = wr;
      exe_wide   = wide;
      rf_grant   = g;
      exe_dest   = d;
      exe_result = r;
   endtask

   task automatic idle(input logic g, input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, g, '0, '0);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         chk("count", 128'(count), 128'(m_q.size()));
         chk("stall_exe", 128'(stall_exe), 128'(m_q.size() >= DEPTH - 1));
         chk("overflow_err", 128'(overflow_err), 128'(m_ovf));
         chk("sb_clr", 128'(sb_clr), 128'(m_sb));
         chk("rf_wr_en", 128'(rf_wr_en), 128'(m_q.size() != 0));
         if (m_q.size() != 0 && exp_wr.size() != 0) begin
            chk("rf_wr_idx", 128'(rf_wr_idx), 128'(exp_wr[0].idx));
            chk("rf_wr_data", 128'(rf_wr_data), 128'(exp_wr[0].data));
            if (rf_grant) void'(exp_wr.pop_front());
         end
      end
   end

   initial begin
      reset = 1'b1; exe_valid = 0; exe_wr_en = 0; exe_wide = 0; rf_grant = 0;
      exe_dest = '0; exe_result = '0;
      m_half = 0; m_ovf = 0; m_sb = '0; last_accept = 0;
      step(1, 0, 0, 0, 0, '0, '0);
      mon_en = 1'b1;
      step(1, 0, 0, 0, 0, '0, '0);

      // Single narrow result, then a wide one.
      step(0, 1, 1, 0, 1, 4'd3, 128'hDEADBEEF);
      idle(1, 3);
      step(0, 1, 1, 1, 1, 4'd0, {64'h1111, 64'h2222});
      idle(1, 4);

      // Fill with grant held low, one extra push overflows, then drain in order.
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, IDX_W'(4 + i), rnd128());
      idle(0, 1);
      idle(1, 8);

      // Full FIFO with a push coinciding with a granted pop.
      step(1, 0, 0, 0, 0, '0, '0);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, IDX_W'(10 + i), rnd128());
      step(0, 1, 1, 0, 1, 4'd9, rnd128());
      idle(1, 8);

      // Flags-only op.
      step(0, 1, 0, 0, 1, 4'd5, rnd128());
      idle(1, 3);

      // Reset during the high-half write of a wide entry.
      step(0, 1, 1, 1, 0, 4'd7, rnd128());
      step(0, 0, 0, 0, 1, '0, '0);
      step(1, 0, 0, 0, 0, '0, '0);
      idle(1, 3);

      // Wide entry targeting the high-half register itself.
      step(0, 1, 1, 1, 1, IDX_W'(HI_IDX), rnd128());
      idle(1, 4);

      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 255) == 0), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3),
              ($urandom_range(0, 9) < 6), IDX_W'($urandom()), rnd128());
      end

      idle(1, 3 * DEPTH + 4);
      @(negedge clk);
      #1;
      chk("drained", 128'(exp_wr.size()), 128'(0));
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
